rf_read_port_arbiter: RTL
=========================

Name: rf_read_port_arbiter

Overview:
- Shares one 16x1 32-bit register-file read mux between four requesters (fetch, decode operand A/B, load/store multiple sequencer).
- Drives the mux Sel with round-robin arbitration and supports multi-register bursts of consecutive registers.
- Registers the mux output and routes it back to the owning requester with a valid and last flag.
- Sits between the control unit and the register-file read mux; the mux itself is instantiated outside this block.

Parameters:
NREQ, 4, number of requesters (design and verification cover only 4)
DW, 32, data width of mux output
AW, 4, register address width (16 registers)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
Req  input  NREQ  level request per requester
Addr  input  NREQ*AW  start register per requester; requester i uses bits [4i+3:4i]
Len  input  NREQ*AW  burst length minus 1 per requester; same packing as Addr
Hold  input  1  stall: no beat is issued at a posedge while high
Sel  output  AW  select to register-file mux (registered)
Y  input  DW  mux output, combinational from Sel
Gnt  output  NREQ  one-hot grant, one-cycle pulse on the first beat only
RdData  output  DW  registered read data
RdValid  output  NREQ  one-hot data valid for owner
RdLast  output  1  marks final beat of a grant
Busy  output  1  burst in progress or beat in flight

Behaviour:
- Reset (async, Reset=0):
  - Sel=0, Gnt=0, RdData=0, RdValid=0, RdLast=0, Busy=0.
  - State=IDLE, round-robin pointer ptr=0, in-flight flag iss=0.
- Beat: Sel value presented for one cycle. A beat issued at posedge t returns data at posedge t+1 (RdData<=Y, RdValid=onehot(owner)).
- IDLE, posedge with Hold=0 and any Req:
  - Winner w = first set Req scanning from ptr upward, wrapping 3->0.
  - Gnt<=onehot(w), Sel<=Addr[w], owner<=w, cnt<=Len[w], iss<=1, ptr<=(w+1) mod 4.
  - Last<=(Len[w]==0). If Len[w]!=0, state<=BURST; otherwise stay IDLE and arbitrate again next posedge.
- IDLE, no Req or Hold=1: Gnt<=0, iss<=0, Sel holds its value.
- BURST, posedge with Hold=0:
  - Sel<=Sel+1, wrapping 15->0. cnt<=cnt-1. iss<=1. Gnt<=0.
  - When cnt==1, last<=1 and state<=IDLE.
- BURST, Hold=1: Sel and cnt frozen, iss<=0.
- Req is ignored in BURST; there is no preemption.
- Total beats per grant = Len+1, from 1 to 16.
- Req is level-sensitive. If Req[i] is still high at the posedge after Gnt[i], it is a new request. A requester wanting one grant drops Req while Gnt is high.
- Data stage, every posedge:
  - RdData<=Y.
  - RdValid<=iss ? onehot(owner) : 0.
  - RdLast<=iss & last.
  - Hold does not stall the data stage: an issued beat always returns.
- Busy = (state==BURST) | iss.
- Latency: Req sampled at posedge t gives Gnt and Sel in cycle t, RdValid in cycle t+1.
- Throughput: 1 beat per cycle, including back-to-back single grants to different requesters.
- Reset mid-burst: immediate clear; the burst is abandoned; no RdValid or RdLast is produced for remaining beats.

Test Plan:
- Y modelled as 0xA000_0000+Sel. Release reset; Req=0001, Addr0=5, Len0=0 -> Gnt=0001 one cycle; Sel=5; next cycle RdValid=0001, RdData=0xA0000005, RdLast=1; Busy high for 1 cycle.
- Req=1111 held, all Len=0, Addr_i=i -> Gnt sequence 0001,0010,0100,1000,0001; RdValid follows one cycle later with no gaps; RdLast=1 each beat.
- Req=0100, Addr2=14, Len2=3 -> Sel 14,15,0,1; four RdValid=0100 pulses with data 0xA000000E,F,0,1; RdLast on 4th only. Req1 raised mid-burst -> Gnt=0010 at the posedge after Sel=1 is issued.
- Same burst with Hold=1 for 2 cycles after beat 2 -> Sel frozen at 15; 2-cycle RdValid gap; still exactly 4 beats; RdLast on Sel=1 data.
- Reset pulsed low during beat 2 of a Len=7 burst -> all outputs 0 immediately; no further RdValid. After release, Req=1001 -> requester 0 wins (ptr=0).
- Req=0001, Addr0=0, Len0=15 -> 16 beats Sel 0..15; RdLast only with data 0xA000000F; Busy low the cycle after.

Source files
------------

// File: rtl/rf_read_port_arbiter_if.sv
`default_nettype none
// =============================================================================
// rf_read_port_arbiter_if : request/grant and read-return bundle for the
// shared register-file read-port arbiter.                      Rev 1.0
// =============================================================================
interface rf_read_port_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int AW   = 4
);
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*AW-1:0] len;
   logic               hold;
   logic [AW-1:0]      sel;
   logic [DW-1:0]      y;
   logic [NREQ-1:0]    gnt;
   logic [DW-1:0]      rd_data;
   logic [NREQ-1:0]    rd_valid;
   logic               rd_last;
   logic               busy;

   // Environment side: control unit requesters plus the external read mux
   modport master (
      output req, addr, len, hold, y,
      input  sel, gnt, rd_data, rd_valid, rd_last, busy
   );

   modport slave (
      input  req, addr, len, hold, y,
      output sel, gnt, rd_data, rd_valid, rd_last, busy
   );
endinterface
`default_nettype wire

// File: rtl/rf_read_port_arbiter.sv
`default_nettype none
// =============================================================================
// rf_read_port_arbiter : round-robin, burst-capable arbiter driving a shared
// register-file read mux select and returning registered data.  Rev 1.0
// =============================================================================
module rf_read_port_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int AW   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   rf_read_port_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   sel_q, sel_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            iss_q, iss_d;
   logic            last_q, last_d;
   logic [DW-1:0]   rd_data_q, rd_data_d;
   logic [NREQ-1:0] rd_valid_q, rd_valid_d;
   logic            rd_last_q, rd_last_d;

   logic [AW-1:0]   addr_w [NREQ];
   logic [AW-1:0]   len_w  [NREQ];
   logic            win_found;
   logic [PW-1:0]   win_idx;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_w[g] = bus.addr[g*AW +: AW];
      assign len_w[g]  = bus.len[g*AW +: AW];
   end

   function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
      return PW'((int'(base) + k) % NREQ);
   endfunction

   // Scan downward so the requester closest to ptr overwrites the others
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req[rr_idx(ptr_q, k)]) begin
            win_found = 1'b1;
            win_idx   = rr_idx(ptr_q, k);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      gnt_d   = '0;
      iss_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (!bus.hold && win_found) begin
               gnt_d[win_idx] = 1'b1;
               sel_d          = addr_w[win_idx];
               owner_d        = win_idx;
               cnt_d          = len_w[win_idx];
               iss_d          = 1'b1;
               ptr_d          = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
               last_d         = (len_w[win_idx] == '0);
               if (len_w[win_idx] != '0) begin
                  state_d = BURST;
               end
            end
         end
         BURST: begin
            // Requests are ignored here: a burst is never preempted
            if (!bus.hold) begin
               sel_d  = sel_q + 1'b1;
               cnt_d  = cnt_q - 1'b1;
               iss_d  = 1'b1;
               last_d = (cnt_q == AW'(1));
               if (cnt_q == AW'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Data stage is never stalled: a beat issued last cycle always returns
      rd_data_d  = bus.y;
      rd_valid_d = '0;
      if (iss_q) begin
         rd_valid_d[owner_q] = 1'b1;
      end
      rd_last_d  = iss_q & last_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         cnt_q      <= '0;
         sel_q      <= '0;
         gnt_q      <= '0;
         iss_q      <= 1'b0;
         last_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= '0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         gnt_q      <= gnt_d;
         iss_q      <= iss_d;
         last_q     <= last_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
      end
   end

   assign bus.sel      = sel_q;
   assign bus.gnt      = gnt_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_last  = rd_last_q;
   assign bus.busy     = (state_q == BURST) | iss_q;

endmodule
`default_nettype wire
